combat_resolver: RTL and testbench

- Per-frame hit resolver for N fighters. Sits between the per-player attack/move blocks and the per-player animation FSMs, and drives their `hitstun_active` inputs.
- On each frame tick it snapshots every player's position, facing and hit window, then sequentially tests every attacker/victim pair for hitbox-vs-hurtbox overlap.
- It applies damage and hitstun, limits each attack swing to one hit, and detects KO and end of round.

---
 rtl/combat_pkg.sv | 45 ++++
 rtl/box_overlap.sv | 30 +++
 rtl/combat_resolver.sv | 190 +++++++++++++++++++
 tb/tb_combat_resolver.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combat_pkg.sv
// Shared types and geometry for the combat resolver: box offsets, FSM states,
// signed screen coordinates and packed-bus helpers.
package combat_pkg;

    localparam int MAX_PLAYERS = 4;
    localparam int BUS_W       = 10 * MAX_PLAYERS;

    localparam int HIT_W      = 40;
    localparam int HIT_H      = 80;
    localparam int HIT_FWD_X  = 85;
    localparam int HIT_BACK_X = 35;
    localparam int HIT_Y      = 35;
    localparam int HURT_W     = 40;
    localparam int HURT_H     = 45;
    localparam int HURT_CX    = 60;
    localparam int HURT_CY    = 75;

    // 12-bit signed so boxes that hang off the left/top edge stay negative.
    typedef logic signed [11:0] coord_t;

    localparam coord_t HIT_X0_FWD  = coord_t'(HIT_FWD_X);
    localparam coord_t HIT_X0_BACK = coord_t'(HIT_BACK_X - HIT_W);
    localparam coord_t HIT_Y0      = coord_t'(HIT_Y - HIT_H / 2);
    localparam coord_t HURT_X0     = coord_t'(HURT_CX - HURT_W / 2);
    localparam coord_t HURT_Y0     = coord_t'(HURT_CY - HURT_H / 2);
    localparam coord_t HIT_WC      = coord_t'(HIT_W);
    localparam coord_t HIT_HC      = coord_t'(HIT_H);
    localparam coord_t HURT_WC     = coord_t'(HURT_W);
    localparam coord_t HURT_HC     = coord_t'(HURT_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    function automatic logic [9:0] unpack_coord(input logic [BUS_W-1:0] bus, input logic [1:0] idx);
        return bus[10*idx +: 10];
    endfunction

    function automatic coord_t to_coord(input logic [9:0] v);
        return coord_t'({2'b00, v});
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational attacker-hitbox versus victim-hurtbox overlap test.
module box_overlap
    import combat_pkg::*;
(
    input  logic [9:0] i_ax,
    input  logic [9:0] i_ay,
    input  logic       i_a_right,
    input  logic [9:0] i_vx,
    input  logic [9:0] i_vy,
    output logic       o_hit
);

    coord_t w_x0a, w_x1a, w_y0a, w_y1a;
    coord_t w_x0v, w_x1v, w_y0v, w_y1v;

    assign w_x0a = to_coord(i_ax) + (i_a_right ? HIT_X0_FWD : HIT_X0_BACK);
    assign w_x1a = w_x0a + HIT_WC;
    assign w_y0a = to_coord(i_ay) + HIT_Y0;
    assign w_y1a = w_y0a + HIT_HC;

    assign w_x0v = to_coord(i_vx) + HURT_X0;
    assign w_x1v = w_x0v + HURT_WC;
    assign w_y0v = to_coord(i_vy) + HURT_Y0;
    assign w_y1v = w_y0v + HURT_HC;

    // Upper bounds are exclusive: touching edges do not count as contact.
    assign o_hit = (w_x0a < w_x1v) && (w_x0v < w_x1a) &&
                   (w_y0a < w_y1v) && (w_y0v < w_y1a);

endmodule

// File: rtl/combat_resolver.sv
// Per-frame hit resolver: snapshots fighters on SCEN, scans every attacker/victim
// pair one per cycle, then applies damage, hitstun, KO and round-over in one cycle.
module combat_resolver
    import combat_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int HP_W           = 7,
    parameter int MAX_HP         = 100,
    parameter int DAMAGE         = 10,
    parameter int HITSTUN_FRAMES = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        SCEN,
    input  logic [NUM_PLAYERS*10-1:0]   pos_x,
    input  logic [NUM_PLAYERS*10-1:0]   pos_y,
    input  logic [NUM_PLAYERS-1:0]      facing_right,
    input  logic [NUM_PLAYERS-1:0]      attack_damage,
    input  logic [NUM_PLAYERS-1:0]      attack_active,
    output logic [NUM_PLAYERS*HP_W-1:0] health,
    output logic [NUM_PLAYERS-1:0]      hitstun_active,
    output logic [NUM_PLAYERS-1:0]      ko,
    output logic [NUM_PLAYERS-1:0]      hit_event,
    output logic                        round_over,
    output logic                        busy,
    output logic                        overrun
);

    localparam int IDX_W = $clog2(NUM_PLAYERS);
    localparam int HS_W  = $clog2(HITSTUN_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAYERS - 1);

    state_t                    r_state, w_state_next;
    logic [IDX_W-1:0]          r_a, r_v;
    logic [NUM_PLAYERS*10-1:0] r_snap_x, r_snap_y;
    logic [NUM_PLAYERS-1:0]    r_snap_face, r_snap_dmg;
    logic [NUM_PLAYERS-1:0]    r_latched, r_latch_next, r_pending;
    logic [NUM_PLAYERS-1:0]    r_ko, r_hit_event, r_hs_active;
    logic [NUM_PLAYERS-1:0]    w_ko_next;
    logic [HP_W-1:0]           r_hp [NUM_PLAYERS];
    logic [HS_W-1:0]           r_hs [NUM_PLAYERS];
    logic [HP_W-1:0]           w_hp_next [NUM_PLAYERS];
    logic [HS_W-1:0]           w_hs_next [NUM_PLAYERS];
    logic                      r_round_over, r_overrun;
    logic                      w_snap, w_scan, w_apply, w_last_pair, w_overlap, w_pair_hit;
    logic [2:0]                w_alive_cnt;
    logic [9:0]                w_ax, w_ay, w_vx, w_vy;

    assign w_last_pair = (r_a == LAST_IDX) && (r_v == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        w_snap       = 1'b0;
        w_scan       = 1'b0;
        w_apply      = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Once the round is over every SCEN is ignored and all state freezes.
                if (SCEN && !r_round_over) begin
                    w_snap       = 1'b1;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy   = 1'b1;
                w_scan = 1'b1;
                if (w_last_pair) w_state_next = ST_APPLY;
            end
            ST_APPLY: begin
                busy         = 1'b1;
                w_apply      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_ax = unpack_coord(BUS_W'(r_snap_x), 2'(r_a));
    assign w_ay = unpack_coord(BUS_W'(r_snap_y), 2'(r_a));
    assign w_vx = unpack_coord(BUS_W'(r_snap_x), 2'(r_v));
    assign w_vy = unpack_coord(BUS_W'(r_snap_y), 2'(r_v));

    box_overlap u_box_overlap (
        .i_ax      (w_ax),
        .i_ay      (w_ay),
        .i_a_right (r_snap_face[r_a]),
        .i_vx      (w_vx),
        .i_vy      (w_vy),
        .o_hit     (w_overlap)
    );

    assign w_pair_hit = w_scan && (r_a != r_v) && r_snap_dmg[r_a] && !r_latched[r_a] &&
                        !r_hs_active[r_v] && !r_ko[r_v] && !r_ko[r_a] && w_overlap;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic [HP_W-1:0] w_hp_dec;
            assign w_hp_dec = (r_hp[gi] > HP_W'(DAMAGE)) ? r_hp[gi] - HP_W'(DAMAGE) : '0;
            assign w_hp_next[gi] = (w_apply && r_pending[gi]) ? w_hp_dec : r_hp[gi];
            assign w_hs_next[gi] = (w_apply && r_pending[gi])   ? HS_W'(HITSTUN_FRAMES) :
                                   (w_snap && r_hs[gi] != '0)   ? r_hs[gi] - 1'b1 : r_hs[gi];
            assign w_ko_next[gi] = (w_hp_next[gi] == '0);
            assign health[gi*HP_W +: HP_W] = r_hp[gi];
        end
    endgenerate

    always_comb begin
        w_alive_cnt = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_alive_cnt = w_alive_cnt + {2'b00, ~w_ko_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ko        <= '0;
            r_hs_active <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_hp[i] <= HP_W'(MAX_HP);
                r_hs[i] <= '0;
            end
        end else begin
            r_ko <= w_ko_next;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_hp[i]        <= w_hp_next[i];
                r_hs[i]        <= w_hs_next[i];
                r_hs_active[i] <= (w_hs_next[i] != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_v          <= '0;
            r_snap_x     <= '0;
            r_snap_y     <= '0;
            r_snap_face  <= '0;
            r_snap_dmg   <= '0;
            r_latched    <= '0;
            r_latch_next <= '0;
            r_pending    <= '0;
            r_hit_event  <= '0;
            r_round_over <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hit_event <= '0;
            if (SCEN && busy) r_overrun <= 1'b1;
            if (w_snap) begin
                r_snap_x     <= pos_x;
                r_snap_y     <= pos_y;
                r_snap_face  <= facing_right;
                r_snap_dmg   <= attack_damage;
                r_latched    <= r_latched & attack_active;
                r_latch_next <= '0;
                r_pending    <= '0;
                r_a          <= '0;
                r_v          <= '0;
            end
            if (w_scan) begin
                if (w_pair_hit) begin
                    r_pending[r_v]    <= 1'b1;
                    r_latch_next[r_a] <= 1'b1;
                end
                if (r_v == LAST_IDX) begin
                    r_v <= '0;
                    r_a <= r_a + 1'b1;
                end else begin
                    r_v <= r_v + 1'b1;
                end
            end
            if (w_apply) begin
                r_hit_event <= r_pending;
                r_latched   <= r_latched | r_latch_next;
                if (w_alive_cnt <= 3'd1) r_round_over <= 1'b1;
            end
        end
    end

    assign hitstun_active = r_hs_active;
    assign ko             = r_ko;
    assign hit_event      = r_hit_event;
    assign round_over     = r_round_over;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_combat_resolver.sv
// Scoreboard bench for combat_resolver with two fighters: expected frame results
// are queued as each SCEN is driven and compared when the scan completes.
`timescale 1ns/1ps
module tb_combat_resolver;

    localparam int N       = 2;
    localparam int HP_W    = 7;
    localparam int MAX_HP  = 100;
    localparam int DAMAGE  = 10;
    localparam int HITSTUN = 20;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              SCEN  = 1'b0;
    logic [N*10-1:0]   pos_x = '0;
    logic [N*10-1:0]   pos_y = '0;
    logic [N-1:0]      facing_right  = '0;
    logic [N-1:0]      attack_damage = '0;
    logic [N-1:0]      attack_active = '0;
    logic [N*HP_W-1:0] health;
    logic [N-1:0]      hitstun_active, ko, hit_event;
    logic              round_over, busy, overrun;

    combat_resolver #(
        .NUM_PLAYERS(N), .HP_W(HP_W), .MAX_HP(MAX_HP),
        .DAMAGE(DAMAGE), .HITSTUN_FRAMES(HITSTUN)
    ) dut (
        .clk(clk), .reset(reset), .SCEN(SCEN),
        .pos_x(pos_x), .pos_y(pos_y), .facing_right(facing_right),
        .attack_damage(attack_damage), .attack_active(attack_active),
        .health(health), .hitstun_active(hitstun_active), .ko(ko),
        .hit_event(hit_event), .round_over(round_over), .busy(busy), .overrun(overrun)
    );

    always #20 clk = ~clk;

    typedef struct {
        string             name;
        logic [N*HP_W-1:0] health;
        logic [N-1:0]      hit_event;
        logic [N-1:0]      ko;
        logic              round_over;
        int                latency;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_hp [N];
    logic [N-1:0] m_ko;
    logic       m_ro;

    function automatic logic [N*HP_W-1:0] pack_hp(input int hp0, input int hp1);
        return {HP_W'(hp1), HP_W'(hp0)};
    endfunction

    task automatic set_players(input int x0, input int y0, input logic f0,
                               input int x1, input int y1, input logic f1);
        pos_x        = {10'(x1), 10'(y0 - y0 + x0)};
        pos_y        = {10'(y1), 10'(y0)};
        facing_right = {f1, f0};
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_hp[i] = MAX_HP;
        m_ko = '0;
        m_ro = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; SCEN = 1'b0; attack_damage = '0; attack_active = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one SCEN from a negedge, queues the model's expectation, and checks
    // the first idle cycle after the scan (or immediately, when frozen).
    task automatic frame(input string name, input logic [N-1:0] hits);
        exp_t e, got;
        int   lat, alive;
        e.name      = name;
        e.latency   = m_ro ? 0 : N * N;
        e.hit_event = m_ro ? '0 : hits;
        if (!m_ro) begin
            for (int i = 0; i < N; i++) begin
                if (hits[i]) m_hp[i] = (m_hp[i] > DAMAGE) ? m_hp[i] - DAMAGE : 0;
                m_ko[i] = (m_hp[i] == 0);
            end
            alive = 0;
            for (int i = 0; i < N; i++) if (!m_ko[i]) alive++;
            if (alive <= 1) m_ro = 1'b1;
        end
        for (int i = 0; i < N; i++) e.health[i*HP_W +: HP_W] = HP_W'(m_hp[i]);
        e.ko         = m_ko;
        e.round_over = m_ro;
        sb_q.push_back(e);

        SCEN = 1'b1;
        @(negedge clk);
        SCEN = 1'b0;
        lat = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!busy) begin lat = c; break; end
        end
        got = sb_q.pop_front();
        n_tests++;
        if (lat !== got.latency) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, expected %0d", got.name, lat, got.latency);
        end
        n_tests++;
        if (health !== got.health || hit_event !== got.hit_event ||
            ko !== got.ko || round_over !== got.round_over) begin
            n_fail++;
            $display("FAIL %s result: health=%h hit_event=%b ko=%b round_over=%b, expected health=%h hit_event=%b ko=%b round_over=%b",
                     got.name, health, hit_event, ko, round_over,
                     got.health, got.hit_event, got.ko, got.round_over);
        end
        @(negedge clk);
        n_tests++;
        if (hit_event !== '0) begin
            n_fail++;
            $display("FAIL %s pulse: hit_event=%b one cycle later, expected 00", got.name, hit_event);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (health !== pack_hp(MAX_HP, MAX_HP)) begin
            n_fail++;
            $display("FAIL reset_health: got %h, expected %h", health, pack_hp(MAX_HP, MAX_HP));
        end
        n_tests++;
        if ({hitstun_active, ko, hit_event, round_over, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: hs=%b ko=%b ev=%b ro=%b busy=%b ovr=%b, expected all 0",
                     hitstun_active, ko, hit_event, round_over, busy, overrun);
        end
    endtask

    task automatic test_single_hit_and_hitstun();
        logic [N-1:0] exp_hs;
        do_reset();
        set_players(100, 285, 1'b1, 140, 285, 1'b1);
        attack_damage = 2'b01; attack_active = 2'b01;
        frame("single_hit", 2'b10);
        attack_damage = 2'b00; attack_active = 2'b00;
        n_tests++;
        if (hitstun_active !== 2'b10) begin
            n_fail++;
            $display("FAIL hitstun_start: got %b, expected 10", hitstun_active);
        end
        for (int k = 1; k <= HITSTUN; k++) begin
            frame($sformatf("hitstun_frame%0d", k), 2'b00);
            exp_hs = (k < HITSTUN) ? 2'b10 : 2'b00;
            n_tests++;
            if (hitstun_active !== exp_hs) begin
                n_fail++;
                $display("FAIL hitstun_count k=%0d: got %b, expected %b", k, hitstun_active, exp_hs);
            end
        end
    endtask

    task automatic test_one_hit_per_swing();
        attack_damage = 2'b01; attack_active = 2'b01;
        frame("swing_first", 2'b10);
        for (int k = 1; k <= 24; k++) frame($sformatf("swing_held%0d", k), 2'b00);
        n_tests++;
        if (hitstun_active !== 2'b00) begin
            n_fail++;
            $display("FAIL swing_hitstun_over: got %b, expected 00", hitstun_active);
        end
        attack_damage = 2'b00; attack_active = 2'b00;
        frame("swing_release", 2'b00);
        attack_damage = 2'b01; attack_active = 2'b01;
        frame("swing_retrigger", 2'b10);
    endtask

    task automatic test_trade();
        do_reset();
        set_players(100, 285, 1'b1, 140, 285, 1'b0);
        attack_damage = 2'b11; attack_active = 2'b11;
        frame("trade", 2'b11);
    endtask

    task automatic test_no_wrap();
        do_reset();
        set_players(0, 285, 1'b0, 600, 285, 1'b1);
        attack_damage = 2'b01; attack_active = 2'b01;
        frame("left_edge_no_wrap", 2'b00);
    endtask

    task automatic test_ko_round();
        do_reset();
        set_players(100, 285, 1'b1, 140, 285, 1'b1);
        for (int s = 0; s < 10; s++) begin
            attack_damage = 2'b01; attack_active = 2'b01;
            frame($sformatf("ko_swing%0d", s), 2'b10);
            if (s < 9) begin
                attack_damage = 2'b00; attack_active = 2'b00;
                for (int k = 0; k < HITSTUN; k++) frame("ko_recover", 2'b00);
            end
        end
        n_tests++;
        if (ko !== 2'b10 || round_over !== 1'b1 || health !== pack_hp(MAX_HP, 0)) begin
            n_fail++;
            $display("FAIL ko_state: ko=%b ro=%b health=%h, expected ko=10 ro=1 health=%h",
                     ko, round_over, health, pack_hp(MAX_HP, 0));
        end
        set_players(100, 285, 1'b1, 140, 285, 1'b0);
        attack_damage = 2'b11; attack_active = 2'b11;
        for (int k = 0; k < 3; k++) frame($sformatf("frozen%0d", k), 2'b11);
    endtask

    task automatic test_overrun();
        int lat;
        do_reset();
        set_players(100, 285, 1'b1, 140, 285, 1'b1);
        attack_damage = 2'b01; attack_active = 2'b01;
        SCEN = 1'b1; @(negedge clk);
        SCEN = 1'b0; @(negedge clk);
        SCEN = 1'b1; @(negedge clk);
        SCEN = 1'b0;
        lat = -1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!busy) begin lat = c; break; end
        end
        n_tests++;
        if (lat < 0 || overrun !== 1'b1 || health !== pack_hp(MAX_HP, MAX_HP - DAMAGE) ||
            hit_event !== 2'b10) begin
            n_fail++;
            $display("FAIL overrun: lat=%0d ovr=%b health=%h ev=%b, expected ovr=1 health=%h ev=10",
                     lat, overrun, health, hit_event, pack_hp(MAX_HP, MAX_HP - DAMAGE));
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || health !== pack_hp(MAX_HP, MAX_HP - DAMAGE)) begin
            n_fail++;
            $display("FAIL overrun_ignored: busy=%b health=%h, expected busy=0 health=%h",
                     busy, health, pack_hp(MAX_HP, MAX_HP - DAMAGE));
        end
    endtask

    task automatic test_reset_mid_scan();
        logic bad;
        do_reset();
        set_players(100, 285, 1'b1, 140, 285, 1'b1);
        attack_damage = 2'b01; attack_active = 2'b01;
        SCEN = 1'b1; @(negedge clk);
        SCEN = 1'b0; @(negedge clk);
        reset = 1'b1; @(negedge clk);
        n_tests++;
        if (health !== pack_hp(MAX_HP, MAX_HP) ||
            {hitstun_active, ko, hit_event, round_over, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL midscan_reset: health=%h hs=%b ko=%b ev=%b ro=%b busy=%b ovr=%b, expected %h and flags 0",
                     health, hitstun_active, ko, hit_event, round_over, busy, overrun,
                     pack_hp(MAX_HP, MAX_HP));
        end
        reset = 1'b0;
        model_reset();
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (hit_event !== '0 || busy !== 1'b0 || health !== pack_hp(MAX_HP, MAX_HP)) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL midscan_no_damage: late activity after reset, health=%h", health);
        end
        frame("after_reset", 2'b10);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_hit_and_hitstun();
        test_one_hit_per_swing();
        test_trade();
        test_no_wrap();
        test_ko_round();
        test_overrun();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
